// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - video timing generator and pixel output stage
// Fetch coordinates lead the display outputs by LATENCY+1 cycles to cover the GPU plus the color register.
module vga_scanout #(
  parameter int   COORD_WIDTH = 10,
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   LATENCY     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [COORD_WIDTH-1:0] x_coord,
  output logic [COORD_WIDTH-1:0] y_coord,
  output logic                   copy_start,
  input  logic [15:0]            gpu_color,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de,
  output logic [4:0]             r,
  output logic [5:0]             g,
  output logic [4:0]             b
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HCW     = $clog2(H_TOTAL + 1);
  localparam int VCW     = $clog2(V_TOTAL + 1);

  localparam logic [HCW-1:0] H_LAST     = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_ACT      = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] HS_START   = HCW'(H_ACTIVE + H_FRONT);
  localparam logic [HCW-1:0] HS_END     = HCW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VCW-1:0] V_LAST     = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_ACT      = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] VS_START   = VCW'(V_ACTIVE + V_FRONT);
  localparam logic [VCW-1:0] VS_END     = VCW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [HCW-1:0]     h_cnt;
  logic [VCW-1:0]     v_cnt;
  logic               act;
  logic               hs;
  logic               vs;
  logic               reload;
  logic [LATENCY-1:0] act_d;
  logic [LATENCY-1:0] hs_d;
  logic [LATENCY-1:0] vs_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VCW'(1);
    end else begin
      h_cnt <= h_cnt + HCW'(1);
    end
  end

  // The counters are the fetch registers; the coordinates are their truncated view.
  assign x_coord = COORD_WIDTH'(h_cnt);
  assign y_coord = COORD_WIDTH'(v_cnt);

  always_comb begin
    act    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs     = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs     = (v_cnt >= VS_START) && (v_cnt < VS_END);
    reload = (h_cnt == '0) && (v_cnt == V_ACT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_d <= '0;
      hs_d  <= '0;
      vs_d  <= '0;
    end else begin
      act_d[0] <= act;
      hs_d[0]  <= hs;
      vs_d[0]  <= vs;
      for (int i = 1; i < LATENCY; i++) begin
        act_d[i] <= act_d[i-1];
        hs_d[i]  <= hs_d[i-1];
        vs_d[i]  <= vs_d[i-1];
      end
    end
  end

  // Output register: captures the GPU color in the same cycle as the delayed timing flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      de         <= 1'b0;
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
      r          <= '0;
      g          <= '0;
      b          <= '0;
      copy_start <= 1'b0;
    end else begin
      de         <= act_d[LATENCY-1];
      hsync      <= hs_d[LATENCY-1] ? SYNC_POL : ~SYNC_POL;
      vsync      <= vs_d[LATENCY-1] ? SYNC_POL : ~SYNC_POL;
      r          <= act_d[LATENCY-1] ? gpu_color[15:11] : 5'd0;
      g          <= act_d[LATENCY-1] ? gpu_color[10:5]  : 6'd0;
      b          <= act_d[LATENCY-1] ? gpu_color[4:0]   : 5'd0;
      copy_start <= reload;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - scoreboard bench for vga_scanout at LATENCY 1, 2 and 4
// Reduced timing (32x15 total, 16x8 visible) keeps whole frames short.
module tb_vga_scanout;

  localparam int HA = 16, HF = 4, HSW = 6, HB = 6, HT = HA + HF + HSW + HB;
  localparam int VA = 8, VF = 2, VSW = 2, VB = 3, VT = VA + VF + VSW + VB;
  localparam logic [18:0] IDLE = {1'b0, 1'b1, 1'b1, 16'h0};

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  xc [3];
  logic [9:0]  yc [3];
  logic        cs [3];
  logic        hs [3];
  logic        vs [3];
  logic        de [3];
  logic [4:0]  rr [3];
  logic [5:0]  gg [3];
  logic [4:0]  bb [3];
  logic [15:0] col [3];

  int lat_of [3] = '{1, 2, 4};

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;
    logic [15:0] pipe [LAT];

    vga_scanout #(
      .COORD_WIDTH(10), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB), .SYNC_POL(1'b0), .LATENCY(LAT)
    ) u_dut (
      .clk(clk), .reset(reset), .x_coord(xc[gi]), .y_coord(yc[gi]), .copy_start(cs[gi]),
      .gpu_color(col[gi]), .hsync(hs[gi]), .vsync(vs[gi]), .de(de[gi]),
      .r(rr[gi]), .g(gg[gi]), .b(bb[gi])
    );

    // GPU stub: fixed-latency pipeline of a coordinate-derived color
    always @(posedge clk) begin
      pipe[0] <= {yc[gi][4:0], xc[gi][5:0], xc[gi][4:0]};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign col[gi] = pipe[LAT-1];
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int mh, mv, cyc, de_cnt, cs_seen;
  int first_hs [3];
  int cs_at [2];
  logic [18:0] sb0 [$];
  logic [18:0] sb1 [$];
  logic [18:0] sb2 [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] exp_pix(input int h, input int v);
    logic act, hsa, vsa;
    logic [15:0] c;
    act = (h < HA) && (v < VA);
    hsa = (h >= HA + HF) && (h < HA + HF + HSW);
    vsa = (v >= VA + VF) && (v < VA + VF + VSW);
    c   = {v[4:0], h[5:0], h[4:0]};
    return {act, ~hsa, ~vsa, act ? c : 16'h0};
  endfunction

  function automatic logic [18:0] obs_pix(input int i);
    return {de[i], hs[i], vs[i], rr[i], gg[i], bb[i]};
  endfunction

  function automatic logic [39:0] obs_rst(input int i);
    return {xc[i], yc[i], cs[i], de[i], hs[i], vs[i], rr[i], gg[i], bb[i]};
  endfunction

  task automatic start_run();
    mh = 0; mv = 0; cyc = 0; de_cnt = 0; cs_seen = 0;
    cs_at[0] = -1; cs_at[1] = -1;
    for (int i = 0; i < 3; i++) first_hs[i] = -1;
    sb0.delete(); sb1.delete(); sb2.delete();
    for (int i = 0; i < 1; i++) sb0.push_back(IDLE);
    for (int i = 0; i < 2; i++) sb1.push_back(IDLE);
    for (int i = 0; i < 4; i++) sb2.push_back(IDLE);
    sb0.push_back(exp_pix(0, 0));
    sb1.push_back(exp_pix(0, 0));
    sb2.push_back(exp_pix(0, 0));
  endtask

  task automatic tick();
    logic exp_cs;
    logic [18:0] e;
    @(posedge clk);
    #1;
    cyc++;
    exp_cs = (mh == 0) && (mv == VA);
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end
    e = exp_pix(mh, mv);
    sb0.push_back(e); sb1.push_back(e); sb2.push_back(e);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("coord_L%0d c%0d", lat_of[i], cyc), {44'h0, xc[i], yc[i]}, {44'h0, 10'(mh), 10'(mv)});
      check($sformatf("copy_start_L%0d c%0d", lat_of[i], cyc), {63'h0, cs[i]}, {63'h0, exp_cs});
      if (!hs[i] && first_hs[i] < 0) first_hs[i] = cyc;
    end
    check($sformatf("pix_L1 c%0d", cyc), {45'h0, obs_pix(0)}, {45'h0, sb0.pop_front()});
    check($sformatf("pix_L2 c%0d", cyc), {45'h0, obs_pix(1)}, {45'h0, sb1.pop_front()});
    check($sformatf("pix_L4 c%0d", cyc), {45'h0, obs_pix(2)}, {45'h0, sb2.pop_front()});
    if (de[1] && cyc <= HT * VT) de_cnt++;
    if (cs[1] && cs_seen < 2) begin
      cs_at[cs_seen] = cyc;
      cs_seen++;
    end
  endtask

  initial begin
    logic found;
    #12;
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_vals_L%0d", lat_of[i]), {24'h0, obs_rst(i)}, {24'h0, 20'h0, 4'b0011, 16'h0});
    @(negedge clk);
    reset = 1'b1;
    start_run();

    for (int n = 0; n < 1000; n++) tick();
    for (int i = 0; i < 3; i++)
      check($sformatf("first_hsync_L%0d", lat_of[i]), 64'(first_hs[i]), 64'(HA + HF + lat_of[i] + 1));
    check("first_copy_start", 64'(cs_at[0]), 64'(HT * VA + 1));
    check("second_copy_start", 64'(cs_at[1]), 64'(HT * VA + 1 + HT * VT));
    check("de_count_frame0", 64'(de_cnt), 64'(HA * VA));

    found = 1'b0;
    for (int n = 0; n < 600 && !found; n++) begin
      tick();
      found = (mh == 10) && (mv == 5);
    end
    check("reach_mid_frame", {63'h0, found}, 64'h1);

    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("async_reset_L%0d", lat_of[i]), {24'h0, obs_rst(i)}, {24'h0, 20'h0, 4'b0011, 16'h0});
    @(negedge clk);
    reset = 1'b1;
    start_run();
    for (int n = 0; n < 300; n++) tick();
    check("copy_after_reset", 64'(cs_at[0]), 64'(HT * VA + 1));
    check("copy_once_after_reset", 64'(cs_seen), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
